// File: rtl/lc3_fetch_queue.sv
// LC3 instruction prefetch queue: circular buffer of {pc, instr} between imem and decode.
// Flush on redirect, next-PC for decode, and a registered PC-sequence error pulse.
module lc3_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [15:0]      in_pc,
    input  logic [15:0]      in_instr,
    output logic             in_ready,
    output logic             out_valid,
    output logic [15:0]      out_pc,
    output logic [15:0]      out_npc,
    output logic [15:0]      out_instr,
    input  logic             out_ready,
    output logic [CNT_W-1:0] count,
    output logic             seq_err
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] instr;
    } entry_t;

    entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [15:0]      last_pc_q, last_pc_d;
    logic             have_last_q, have_last_d;
    logic             seq_err_q, seq_err_d;
    logic             push, pop;
    entry_t           head;

    // Handshakes depend only on state and flush, never on in_valid/out_ready.
    assign in_ready  = !flush && (count_q != CNT_W'(DEPTH));
    assign out_valid = !flush && (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign head      = mem_q[rd_ptr_q];
    assign out_pc    = head.pc;
    assign out_instr = head.instr;
    assign out_npc   = head.pc + 16'd1;
    assign count     = count_q;
    assign seq_err   = seq_err_q;

    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        last_pc_d   = last_pc_q;
        have_last_d = have_last_q;
        seq_err_d   = 1'b0;
        if (flush) begin
            rd_ptr_d    = '0;
            wr_ptr_d    = '0;
            count_d     = '0;
            have_last_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d    = wr_ptr_q + PTR_W'(1);
                last_pc_d   = in_pc;
                have_last_d = 1'b1;
                seq_err_d   = have_last_q && (in_pc != last_pc_q + 16'd1);
            end
            if (pop)
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push && !pop)
                count_d = count_q + CNT_W'(1);
            else if (pop && !push)
                count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            last_pc_q   <= '0;
            have_last_q <= 1'b0;
            seq_err_q   <= 1'b0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            last_pc_q   <= last_pc_d;
            have_last_q <= have_last_d;
            seq_err_q   <= seq_err_d;
        end
    end

    // Storage is not reset; stale contents are unreachable once pointers clear.
    always_ff @(posedge clock) begin
        if (push && !reset)
            mem_q[wr_ptr_q] <= '{pc: in_pc, instr: in_instr};
    end
endmodule

// File: tb/tb_lc3_fetch_queue.sv
// Bench for lc3_fetch_queue: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_lc3_fetch_queue;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clock, reset, flush, in_valid, out_ready;
    logic [15:0]      in_pc, in_instr;
    logic             in_ready, out_valid, seq_err;
    logic [15:0]      out_pc, out_npc, out_instr;
    logic [CNT_W-1:0] count;

    lc3_fetch_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr), .in_ready(in_ready),
        .out_valid(out_valid), .out_pc(out_pc), .out_npc(out_npc), .out_instr(out_instr),
        .out_ready(out_ready), .count(count), .seq_err(seq_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    bit started = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of fetched entries.
    typedef struct {
        logic [15:0] pc;
        logic [15:0] instr;
    } ent_t;
    ent_t        mq[$];
    bit          m_have_last = 0;
    logic [15:0] m_last_pc = '0;
    bit          m_seq = 0;
    bit          m_push, m_pop;
    logic [15:0] m_nxt;

    always @(posedge clock) begin
        if (reset || flush) begin
            mq.delete();
            m_have_last = 0;
            m_seq = 0;
        end else begin
            m_push = in_valid && (mq.size() < DEPTH);
            m_pop  = out_ready && (mq.size() > 0);
            m_nxt  = m_last_pc + 16'd1;
            m_seq  = m_push && m_have_last && (in_pc != m_nxt);
            if (m_pop) void'(mq.pop_front());
            if (m_push) begin
                mq.push_back('{in_pc, in_instr});
                m_last_pc = in_pc;
                m_have_last = 1;
            end
        end
    end

    logic        e_ov, e_ir;
    logic [15:0] e_npc;
    always @(negedge clock) begin
        if (started) begin
            e_ov = !flush && (mq.size() != 0);
            e_ir = !flush && (mq.size() != DEPTH);
            check("m_count", 32'(count), 32'(mq.size()));
            check("m_out_valid", 32'(out_valid), 32'(e_ov));
            check("m_in_ready", 32'(in_ready), 32'(e_ir));
            check("m_seq_err", 32'(seq_err), 32'(m_seq));
            if (e_ov) begin
                e_npc = mq[0].pc + 16'd1;
                check("m_out_pc", 32'(out_pc), 32'(mq[0].pc));
                check("m_out_instr", 32'(out_instr), 32'(mq[0].instr));
                check("m_out_npc", 32'(out_npc), 32'(e_npc));
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input bit v, input logic [15:0] pc, input logic [15:0] ins,
                         input bit ordy, input bit fl);
        in_valid = v; in_pc = pc; in_instr = ins; out_ready = ordy; flush = fl;
    endtask

    initial begin
        reset = 1; flush = 0; in_valid = 0; out_ready = 0; in_pc = '0; in_instr = '0;
        repeat (2) @(posedge clock);
        #1;
        reset = 0;
        started = 1;
        check("rst_count", 32'(count), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_seq_err", 32'(seq_err), 0);

        // Fill with decode stalled
        for (int i = 0; i < 4; i++) begin
            drive(1, 16'h3000 + 16'(i), 16'h1000 + 16'(i), 0, 0);
            step();
        end
        check("fill_count", 32'(count), 4);
        check("fill_in_ready", 32'(in_ready), 0);
        drive(1, 16'h3004, 16'h1004, 0, 0);
        step();
        check("fifth_rejected", 32'(count), 4);

        // Drain in order
        for (int i = 0; i < 4; i++) begin
            drive(0, 16'h0, 16'h0, 1, 0);
            check("drain_pc", 32'(out_pc), 32'h3000 + 32'(i));
            check("drain_npc", 32'(out_npc), 32'h3001 + 32'(i));
            check("drain_instr", 32'(out_instr), 32'h1000 + 32'(i));
            step();
        end
        check("drain_empty", 32'(out_valid), 0);

        // Streaming after a clean flush
        drive(0, 16'h0, 16'h0, 0, 1);
        step();
        for (int i = 0; i < 20; i++) begin
            drive(1, 16'h3000 + 16'(i), 16'h2000 + 16'(i), 1, 0);
            step();
            check("stream_count", 32'(count), 1);
            check("stream_pc", 32'(out_pc), 32'h3000 + 32'(i));
        end

        // Refill to full, then pop with in_valid held
        for (int i = 0; i < 3; i++) begin
            drive(1, 16'h3014 + 16'(i), 16'h2014 + 16'(i), 0, 0);
            step();
        end
        check("full_count", 32'(count), 4);
        drive(1, 16'h3017, 16'h2017, 1, 0);
        #1;
        check("full_pop_in_ready", 32'(in_ready), 0);
        step();
        check("full_pop_count", 32'(count), 3);
        check("full_pop_ready_after", 32'(in_ready), 1);
        check("full_pop_head", 32'(out_pc), 32'h3014);

        // Flush with both handshakes attempted
        drive(1, 16'h3017, 16'h2017, 1, 1);
        #1;
        check("flush_in_ready", 32'(in_ready), 0);
        check("flush_out_valid", 32'(out_valid), 0);
        step();
        check("flush_count", 32'(count), 0);
        drive(1, 16'h3050, 16'h5050, 0, 0);
        step();
        check("post_flush_valid", 32'(out_valid), 1);
        check("post_flush_pc", 32'(out_pc), 32'h3050);
        check("post_flush_seq", 32'(seq_err), 0);

        // Sequence break 3000 -> 3005
        drive(0, 16'h0, 16'h0, 0, 1);
        step();
        drive(1, 16'h3000, 16'h0, 0, 0);
        step();
        check("seq_first", 32'(seq_err), 0);
        drive(1, 16'h3005, 16'h0, 0, 0);
        step();
        check("seq_break", 32'(seq_err), 1);
        drive(0, 16'h0, 16'h0, 0, 0);
        step();
        check("seq_one_cycle", 32'(seq_err), 0);

        // Wrap FFFF -> 0000 is sequential
        drive(0, 16'h0, 16'h0, 0, 1);
        step();
        drive(1, 16'hFFFF, 16'h0, 0, 0);
        step();
        drive(1, 16'h0000, 16'h0, 0, 0);
        step();
        check("seq_wrap", 32'(seq_err), 0);
        check("wrap_count", 32'(count), 2);

        // Reset mid-handshake with two entries held
        drive(1, 16'h0001, 16'h0, 1, 0);
        reset = 1;
        step();
        reset = 0;
        check("rst2_count", 32'(count), 0);
        check("rst2_out_valid", 32'(out_valid), 0);
        check("rst2_in_ready", 32'(in_ready), 1);
        drive(1, 16'h4000, 16'h4444, 0, 0);
        step();
        check("rst2_new_head", 32'(out_pc), 32'h4000);
        check("rst2_new_instr", 32'(out_instr), 32'h4444);
        drive(0, 16'h0, 16'h0, 0, 0);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lc3_fetch_queue.md
# lc3_fetch_queue

Instruction prefetch queue between the LC3 fetch stage (imem read response) and the decode stage. It buffers up to DEPTH fetched {PC, instruction} pairs so that fetch keeps running while decode is stalled. It is flushed on a taken branch or jump signalled by the controller. Decode sees the head entry together with its next-PC (PC+1).

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, at least 2.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  discard all entries (taken branch, JMP, TRAP redirect).
- in_valid  in  1  fetch presents an entry.
- in_pc  in  16  PC of the presented instruction.
- in_instr  in  16  instruction word from imem (dout).
- in_ready  out  1  queue accepts the entry this cycle.
- out_valid  out  1  head entry is valid for decode.
- out_pc  out  16  PC of the head entry.
- out_npc  out  16  out_pc + 1, modulo 2^16.
- out_instr  out  16  instruction of the head entry.
- out_ready  in  1  decode consumes the head entry (decode enable).
- count  out  CNT_W  number of occupied entries, 0..DEPTH.
- seq_err  out  1  one-cycle pulse when a pushed PC is not the previous pushed PC + 1.

## Operation
- Storage is a circular buffer of DEPTH entries, each {pc[15:0], instr[15:0]}. It uses a read pointer and a write pointer of $clog2(DEPTH) bits, plus a count register.
- Both pointers wrap from DEPTH-1 to 0.
- A push occurs when in_valid && in_ready. On a push:
  - the entry is written at the write pointer;
  - the write pointer increments.
- A pop occurs when out_valid && out_ready. On a pop, the read pointer increments.
- count update on each cycle:
  - +1 for a push only;
  - -1 for a pop only;
  - unchanged for a simultaneous push and pop.
- in_ready = !flush && (count != DEPTH). There is no pass-through: a full queue does not accept an entry even if a pop happens in the same cycle.
- out_valid = !flush && (count != 0).
- out_pc, out_instr and out_npc are taken from the entry at the read pointer. Their value is don't-care when out_valid is 0.
- Flush has the highest priority. In a flush cycle:
  - pointers and count go to 0 at the next edge;
  - any push or pop in that cycle is ignored (the handshakes are already blocked by the gating above).
- PC sequence check. A register last_pc and a flag have_last track the most recent push.
  - On a push with have_last = 1 and in_pc != last_pc + 1 (mod 2^16), seq_err pulses high for the cycle after the push.
  - Every push loads last_pc <= in_pc and sets have_last.
  - reset and flush clear have_last, so the first push after either never flags.
  - last_pc = 16'hFFFF followed by in_pc = 16'h0000 is sequential.
- Reset values:
  - count = 0, pointers = 0, have_last = 0, seq_err = 0;
  - in_ready = 1 and out_valid = 0 in the cycle after reset deasserts;
  - storage contents are not reset.
- Reset asserted in any state, including full or mid-handshake, yields the reset values at the next edge. Handshakes in that cycle are discarded.

## Timing
- Latency from push to visibility is 1 cycle. An entry pushed at edge N is the head (if the queue was empty) and out_valid = 1 after edge N.
- in_ready and out_valid are combinational only from count, the pointers and flush. They have no path from in_valid or out_ready.
- Throughput is 1 push and 1 pop per cycle while 0 < count < DEPTH.
- A full queue with a pop at edge N gives count = DEPTH-1 and in_ready = 1 after N.
- An empty queue with a push at edge N gives count = 1. A pop is not possible in cycle N.
- After a flush at edge N, count = 0 after N, and a push is accepted in cycle N+1.
- seq_err is registered and lasts exactly 1 cycle per offending push.

## Test plan
- Reset, then push PCs 3000..3003 (instr 1000..1003) with out_ready = 0. Required: count = 4, in_ready = 0, and a 5th in_valid is not accepted. Then out_ready = 1 for 4 cycles. Required: out_pc 3000, 3001, 3002, 3003 in order, out_npc = out_pc + 1, then out_valid = 0.
- Streaming: in_valid and out_ready held high for 20 cycles from PC 3000. Required: count stays at 1 after the first cycle, and each out_pc is one greater than the previous.
- Full with simultaneous pop: count = 4 and out_ready = 1, in_valid = 1. Required: no push in that cycle, count = 3 after the edge, and in_ready = 1.
- Flush with count = 3 while in_valid and out_ready are high. Required: both handshakes blocked that cycle and count = 0 after. Then push PC 3050. Required: out_pc = 3050 one cycle later and no seq_err.
- Push PC 3000, then PC 3005. Required: seq_err high for exactly one cycle. Also push FFFF then 0000. Required: no seq_err.
- Assert reset while count = 2. Required: count = 0, out_valid = 0, in_ready = 1 after the edge, and the old entries are never presented.
